// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Pushbutton conditioner. The raw pin is brought into the clk_i
//               domain with a two-flop synchronizer, normalised so that 1
//               means pressed, and filtered by a four-state FSM that accepts
//               a level change only after DB_CYCLES consecutive stable
//               samples. A long-press pulse fires once per accepted press
//               after LONG_CYCLES cycles spent in the pressed state.
// Ports       : clk_i        - system clock, rising edge
//               resetn_i     - synchronous active-low reset
//               pb_raw_i     - raw, asynchronous, bouncing button pin
//               pb_level_o   - debounced level, 1 = pressed
//               pb_press_o   - one-cycle pulse on accepted press
//               pb_release_o - one-cycle pulse on accepted release
//               pb_long_o    - one-cycle pulse when held LONG_CYCLES
//               btn_resetn_o - active-low reset request, NOT pb_level_o
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
  parameter int unsigned DB_CYCLES     = 120000,
  parameter int unsigned LONG_CYCLES   = 24000000,
  parameter bit          PB_ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic pb_raw_i,
  output logic pb_level_o,
  output logic pb_press_o,
  output logic pb_release_o,
  output logic pb_long_o,
  output logic btn_resetn_o
);

  localparam int unsigned CNT_W  = $clog2(DB_CYCLES + 1);
  localparam int unsigned LCNT_W = $clog2(LONG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DB_CYCLES - 1);
  localparam logic [LCNT_W-1:0] c_lcnt_max = LCNT_W'(LONG_CYCLES);
  localparam logic [LCNT_W-1:0] c_lcnt_pre = LCNT_W'(LONG_CYCLES - 1);
  // Pin level of a released button; the synchronizer resets to it so that
  // leaving reset never looks like a press.
  localparam logic              c_released = PB_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                long_q, long_d;
  logic                btn_resetn_q, btn_resetn_d;
  logic                pressed_s;

  // Synchronizer and polarity normalisation
  always_comb begin
    sync1_d   = pb_raw_i;
    sync2_d   = sync1_q;
    pressed_s = PB_ACTIVE_LOW ? ~sync2_q : sync2_q;
  end

  // Next-state, counters and registered-output inputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pressed_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_cnt_last) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == c_cnt_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Held-time counter: restarts on every accepted press, advances only in
    // PRESSED, freezes during release bounces and saturates so the long
    // pulse can fire at most once per press.
    lcnt_d = lcnt_q;
    if ((state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED)) begin
      lcnt_d = '0;
    end else if ((state_q == ST_PRESSED) && (lcnt_q != c_lcnt_max)) begin
      lcnt_d = lcnt_q + 1'b1;
    end

    // Outputs are derived from the next state so that the registered
    // versions line up with the state register.
    level_d      = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    press_d      = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);
    release_d    = (state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE);
    long_d       = (state_q == ST_PRESSED) && (lcnt_q == c_lcnt_pre);
    btn_resetn_d = ~level_d;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lcnt_q       <= '0;
      sync1_q      <= c_released;
      sync2_q      <= c_released;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      btn_resetn_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lcnt_q       <= lcnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      btn_resetn_q <= btn_resetn_d;
    end
  end

  assign pb_level_o   = level_q;
  assign pb_press_o   = press_q;
  assign pb_release_o = release_q;
  assign pb_long_o    = long_q;
  assign btn_resetn_o = btn_resetn_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Scoreboard bench for button_debouncer (DB_CYCLES=4,
//               LONG_CYCLES=10, active-low button). A reference model works
//               on run lengths of the synchronised button value: a level
//               flips once the value has disagreed with it for DB_CYCLES+1
//               consecutive samples. Each cycle's predicted outputs are
//               queued; a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 10;

  logic clk;
  logic resetn;
  logic raw;
  logic pb_level, pb_press, pb_release, pb_long, btn_resetn;

  button_debouncer #(
    .DB_CYCLES    (DB),
    .LONG_CYCLES  (LONG),
    .PB_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .pb_raw_i    (raw),
    .pb_level_o  (pb_level),
    .pb_press_o  (pb_press),
    .pb_release_o(pb_release),
    .pb_long_o   (pb_long),
    .btn_resetn_o(btn_resetn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic level;
    logic press;
    logic rel;
    logic lng;
    logic btn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_press_pred = 0;
  int   n_long_pred  = 0;

  // Reference model state
  logic m_sya, m_syb;   // synchronised raw pin history
  logic m_lvl;          // accepted pressed level
  int   m_run;          // consecutive samples disagreeing with m_lvl
  int   m_held;         // stable-pressed cycles since accepted press

  task automatic model_step();
    exp_t e;
    logic s;
    cyc++;
    e.cyc = cyc;
    e.press = 1'b0; e.rel = 1'b0; e.lng = 1'b0;
    if (!resetn) begin
      m_sya = 1'b1; m_syb = 1'b1;
      m_lvl = 1'b0; m_run = 0; m_held = 0;
    end else begin
      s     = ~m_syb;
      m_syb = m_sya;
      m_sya = raw;
      // Stable pressed (no release bounce in progress) accumulates hold time
      if (m_lvl && (m_run == 0) && (m_held < LONG)) begin
        m_held++;
        if (m_held == LONG) begin
          e.lng = 1'b1;
          n_long_pred++;
        end
      end
      if (s != m_lvl) m_run++;
      else            m_run = 0;
      if (m_run == DB + 1) begin
        m_lvl = ~m_lvl;
        m_run = 0;
        if (m_lvl) begin
          e.press = 1'b1;
          m_held  = 0;
          n_press_pred++;
        end else begin
          e.rel = 1'b1;
        end
      end
    end
    e.level = m_lvl;
    e.btn   = ~m_lvl;
    exp_q.push_back(e);
  endtask

  // One clock: the model sees the inputs the DUT samples at this edge,
  // then the next inputs are driven shortly after the edge.
  task automatic tick(input logic r, input logic n_rst);
    @(posedge clk);
    model_step();
    #2;
    raw    = r;
    resetn = n_rst;
  endtask

  task automatic hold(input logic r, input int n);
    for (int i = 0; i < n; i++) tick(r, 1'b1);
  endtask

  task automatic chk(input string name, input int c, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s cycle %0d: got %b, required %b", name, c, act, req);
    end
  endtask

  // Monitor: every cycle presents an output word
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pb_level",   e.cyc, pb_level,   e.level);
      chk("pb_press",   e.cyc, pb_press,   e.press);
      chk("pb_release", e.cyc, pb_release, e.rel);
      chk("pb_long",    e.cyc, pb_long,    e.lng);
      chk("btn_resetn", e.cyc, btn_resetn, e.btn);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    raw    = 1'b1;
    resetn = 1'b0;
    m_sya = 1'b1; m_syb = 1'b1; m_lvl = 1'b0; m_run = 0; m_held = 0;

    // Reset state
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    hold(1'b1, 5);
    // Clean press held long enough for a long pulse
    hold(1'b0, 28);
    // Release bounce of 2 cycles while pressed, then pressed again
    hold(1'b1, 2);
    hold(1'b0, 12);
    // Clean release
    hold(1'b1, 12);
    // Short press bounce: 3 cycles, then DB-boundary bounces
    hold(1'b0, 3);
    hold(1'b1, 8);
    hold(1'b0, DB + 1);
    hold(1'b1, 8);
    hold(1'b0, DB + 2);
    hold(1'b1, 12);
    // Reset during RELEASE_WAIT
    hold(1'b0, 14);
    hold(1'b1, 2);
    tick(1'b1, 1'b0);
    hold(1'b1, 12);
    // Reset during PRESS_WAIT, then a press needing the full filter time
    hold(1'b0, 4);
    tick(1'b0, 1'b0);
    hold(1'b0, 20);
    hold(1'b1, 12);

    // Randomised segments with occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, DB - 1);
        1:       len = $urandom_range(DB, DB + 3);
        2:       len = $urandom_range(LONG, LONG + 20);
        default: len = $urandom_range(1, 2);
      endcase
      if ($urandom_range(0, 39) == 0) begin
        tick(raw, 1'b0);
      end
      hold(1'($urandom_range(0, 1)), len);
    end

    hold(1'b1, 15);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d outputs left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DB_CYCLES, default 120000 (10 ms at 12 MHz), stable-input cycles required to accept a level change; legal range >= 2.
REQ-002 Parameter LONG_CYCLES, default 24000000 (2 s at 12 MHz), pressed-duration cycles before long-press pulse; SHALL exceed DB_CYCLES.
REQ-003 Parameter PB_ACTIVE_LOW, default 1, 1 = raw button reads 0 when pressed.
REQ-004 clk_i  input  1  system clock, 12 MHz BUFG, all logic on rising edge; one clock only.
REQ-005 resetn_i  input  1  synchronous active-low reset from board power-on source.
REQ-006 pb_raw_i  input  1  raw pushbutton pin, asynchronous, bouncing.
REQ-007 pb_level_o  output  1  debounced pressed level, 1 = pressed.
REQ-008 pb_press_o  output  1  one-cycle pulse on accepted press.
REQ-009 pb_release_o  output  1  one-cycle pulse on accepted release.
REQ-010 pb_long_o  output  1  one-cycle pulse once per press when held LONG_CYCLES.
REQ-011 btn_resetn_o  output  1  active-low reset request to the reset manager's resetn_i, equals NOT pb_level_o.

Function
REQ-012 pb_raw_i SHALL pass a 2-flop synchronizer, then polarity normalisation, giving s (1 = pressed); no other logic samples pb_raw_i.
REQ-013 FSM states: IDLE (released stable), PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: s=1 -> PRESS_WAIT with cnt=0; else stay.
REQ-015 PRESS_WAIT: s=1 and cnt<DB_CYCLES-1 -> cnt+1; s=1 and cnt=DB_CYCLES-1 -> PRESSED; s=0 -> IDLE, cnt=0, no pulse.
REQ-016 PRESSED: s=0 -> RELEASE_WAIT with cnt=0; else stay.
REQ-017 RELEASE_WAIT: s=0 and cnt<DB_CYCLES-1 -> cnt+1; s=0 and cnt=DB_CYCLES-1 -> IDLE; s=1 -> PRESSED, cnt=0, no pulse.
REQ-018 All outputs registered; pb_press_o high exactly in the first cycle state=PRESSED after PRESS_WAIT; pb_release_o high exactly in the first cycle state=IDLE after RELEASE_WAIT.
REQ-019 Latency: stable raw press to pb_press_o = DB_CYCLES+3 clk_i cycles; same for release to pb_release_o.
REQ-020 pb_level_o = 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT; btn_resetn_o changes in the same cycle as pb_level_o.
REQ-021 Long counter lcnt cleared on PRESS_WAIT->PRESSED, increments each PRESSED cycle, holds in RELEASE_WAIT, saturates at LONG_CYCLES.
REQ-022 pb_long_o pulses one cycle when lcnt transitions LONG_CYCLES-1 -> LONG_CYCLES; at most once per accepted press, including across release bounces.
REQ-023 Counter widths = clog2 of parameter+1; no wrap-around permitted.
REQ-024 Bounce shorter than DB_CYCLES SHALL produce no pulse and no level change.

Reset
REQ-025 resetn_i=0 sampled at rising edge: state=IDLE, cnt=0, lcnt=0, synchronizer flops=released level, pb_level_o=0, pulses=0, btn_resetn_o=1.
REQ-026 Reset mid-operation (any state) SHALL abort without emitting press/release/long pulses; first accepted press after reset needs full DB_CYCLES.

Verification (DB_CYCLES=4, LONG_CYCLES=10, PB_ACTIVE_LOW=1)
REQ-027 pb_raw_i 1->0 held -> pb_press_o=1 for one cycle 7 cycles after edge, pb_level_o=1, btn_resetn_o=0 same cycle.
REQ-028 pb_raw_i low 3 cycles then high -> no pulses, pb_level_o stays 0.
REQ-029 Press held 20 cycles after pb_press_o -> single pb_long_o pulse 10 cycles after pb_press_o, none after.
REQ-030 Pressed, raw high 2 cycles then low again -> no pb_release_o, pb_level_o stays 1, no second pb_long_o.
REQ-031 Released stable after press -> pb_release_o one cycle 7 cycles after rising raw edge, btn_resetn_o=1.
REQ-032 resetn_i=0 during RELEASE_WAIT -> next cycle all outputs at REQ-025 values, no pb_release_o.
